contadorg_updown_m_core: RTL and testbench

//  Parameterised modulo-M "ping-pong" (bounce) counter: counts 0..M-1 upward, then reverses
//  and counts down to 0, reverses again, and so on, while enabled. Direction is internal

---
 rtl/contadorg_updown_m_core_pkg.sv | 10 +
 rtl/contadorg_updown_m_core.sv | 78 +++++++
 tb/tb_contadorg_updown_m_core.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/contadorg_updown_m_core_pkg.sv
// Shared types for the bounce counter: the direction register is kept as a named
// two-state enum so the state is readable in waveforms and checkers.
package contadorg_updown_m_core_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/contadorg_updown_m_core.sv
// Modulo-M ping-pong counter: 0..M-1 upward, then back down to 0, repeating while
// conta is high. The endpoints are each held for exactly one enabled cycle.
module contadorg_updown_m_core
    import contadorg_updown_m_core_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 3
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         inicio,
    output logic         fim,
    output logic         meio,
    output logic         direcao
);

    localparam logic [N-1:0] LAST   = N'(M - 1);
    localparam logic [N-1:0] BEFORE = N'(M - 2);
    localparam logic [N-1:0] MID    = N'(M / 2 - 1);
    localparam logic [N-1:0] ONE    = N'(1);

    dir_t         dir_q;
    dir_t         dir_next;
    logic [N-1:0] q_next;

    // Turnaround happens on the same edge that leaves an endpoint, so no cycle is lost.
    // An out-of-range Q (only reachable by forcing) is folded into the top turnaround.
    always_comb begin
        q_next   = Q;
        dir_next = dir_q;
        if (conta) begin
            case (dir_q)
                DIR_UP: begin
                    if (Q >= LAST) begin
                        q_next   = BEFORE;
                        dir_next = DIR_DOWN;
                    end else begin
                        q_next = Q + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (Q == '0) begin
                        q_next   = ONE;
                        dir_next = DIR_UP;
                    end else begin
                        q_next = Q - ONE;
                    end
                end
                default: begin
                    q_next   = '0;
                    dir_next = DIR_UP;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (zera_as) begin
            Q     <= '0;
            dir_q <= DIR_UP;
        end else if (zera_s) begin
            Q     <= '0;
            dir_q <= DIR_UP;
        end else begin
            Q     <= q_next;
            dir_q <= dir_next;
        end
    end

    assign direcao = dir_q;
    assign inicio  = (Q == '0);
    assign fim     = (Q == LAST);
    assign meio    = (Q == MID);

endmodule

// File: tb/tb_contadorg_updown_m_core.sv
// Directed bench for the M=8 bounce counter: reset, clear, full up/down sweep,
// hold with conta low, and clear/reset overriding an enabled count.
module tb_contadorg_updown_m_core;

    localparam int M = 8;
    localparam int N = 3;

    logic         clock;
    logic         zera_as;
    logic         zera_s;
    logic         conta;
    logic [N-1:0] Q;
    logic         inicio;
    logic         fim;
    logic         meio;
    logic         direcao;

    int n_checks;
    int n_errors;

    contadorg_updown_m_core #(.M(M), .N(N)) dut (
        .clock   (clock),
        .zera_as (zera_as),
        .zera_s  (zera_s),
        .conta   (conta),
        .Q       (Q),
        .inicio  (inicio),
        .fim     (fim),
        .meio    (meio),
        .direcao (direcao)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before any sampling or driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic as_v, input logic s_v, input logic c_v);
        zera_as = as_v;
        zera_s  = s_v;
        conta   = c_v;
    endtask

    // Full observation against hand-computed count, direction and expected flags.
    task automatic expect_state(input string tag, input int q_exp, input logic d_exp);
        check({tag, ".Q"},       32'(Q),       32'(q_exp));
        check({tag, ".direcao"}, 32'(direcao), 32'(d_exp));
        check({tag, ".inicio"},  32'(inicio),  32'(q_exp == 0));
        check({tag, ".fim"},     32'(fim),     32'(q_exp == 7));
        check({tag, ".meio"},    32'(meio),    32'(q_exp == 3));
    endtask

    int down_seq[7] = '{6, 5, 4, 3, 2, 1, 0};

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive(1'b1, 1'b0, 1'b0);
        #2;

        // 1: reset
        step();
        expect_state("reset", 0, 1'b0);

        // 2: zera_s from a nonzero count
        drive(1'b0, 1'b0, 1'b1);
        step(); step(); step();
        expect_state("pre_clear", 3, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        expect_state("zera_s", 0, 1'b0);

        // 3: upward sweep 1..7
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step();
            expect_state($sformatf("up%0d", k), k, 1'b0);
        end

        // 4: downward sweep 6..0 then bounce back to 1
        for (int k = 0; k < 7; k++) begin
            step();
            expect_state($sformatf("down%0d", down_seq[k]), down_seq[k], 1'b1);
        end
        step();
        expect_state("bounce_bottom", 1, 1'b0);

        // 5a: hold while counting up at Q=4
        step(); step(); step();
        expect_state("pre_hold_up", 4, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            expect_state($sformatf("hold_up%0d", k), 4, 1'b0);
        end

        // 5b: hold while counting down at Q=6
        drive(1'b0, 1'b0, 1'b1);
        step(); step(); step(); step();
        expect_state("bounce_top", 6, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            expect_state($sformatf("hold_dn%0d", k), 6, 1'b1);
        end

        // 6: zera_s wins over conta at Q=5 counting down
        drive(1'b0, 1'b0, 1'b1);
        step();
        expect_state("pre_clr_dn", 5, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        step();
        expect_state("zera_s_over_conta", 0, 1'b0);

        // zera_as wins over conta mid-count, then counting resumes upward
        drive(1'b0, 1'b0, 1'b1);
        step(); step(); step();
        expect_state("pre_rst_mid", 3, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        step();
        expect_state("zera_as_over_conta", 0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        step();
        expect_state("resume", 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
